// File: rtl/svc_sync_fifo_n.sv
// Synchronous first-word-fall-through FIFO, 2**ADDR_WIDTH entries deep.
// The head entry is visible on rd_data whenever empty is low.
module svc_sync_fifo_n #(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                     (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign rd_data = mem[rptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full)
                wptr <= wptr + PTR_W'(1);
            if (rd_en && !empty)
                rptr <= rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
endmodule

// File: rtl/svc_axi_rd_burst_split.sv
// AXI read burst splitter: reissues each burst as single-beat reads and
// regenerates rlast on the returning beats from a FIFO of burst lengths.
module svc_axi_rd_burst_split #(
    parameter int unsigned AXI_ADDR_WIDTH           = 8,
    parameter int unsigned AXI_DATA_WIDTH           = 16,
    parameter int unsigned AXI_ID_WIDTH             = 4,
    parameter int unsigned AXI_USER_WIDTH           = 1,
    parameter int unsigned OUTSTANDING_BURSTS_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic [AXI_USER_WIDTH-1:0] s_axi_aruser,

    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi_ruser,
    output logic                      s_axi_rlast,

    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [AXI_USER_WIDTH-1:0] m_axi_aruser,

    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic [AXI_USER_WIDTH-1:0] m_axi_ruser
);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                    state;
    logic [7:0]                beats_left;
    logic [7:0]                rcnt;
    logic [7:0]                head_len;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      len_valid;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      pop;
    logic                      arready_idle;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;

    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign len_valid = !fifo_empty;
    assign r_hs      = m_axi_rvalid && s_axi_rready && len_valid;
    assign pop       = r_hs && s_axi_rlast;

    // Look ahead at this cycle's pop so a freed slot reopens arready next cycle.
    assign arready_idle = !(fifo_full && !pop);

    // WRAP and reserved encodings advance like INCR.
    always_comb begin
        next_addr = m_axi_araddr + (AXI_ADDR_WIDTH'(1) << m_axi_arsize);
        case (m_axi_arburst)
            BURST_FIXED: next_addr = m_axi_araddr;
            BURST_INCR:  next_addr = m_axi_araddr + (AXI_ADDR_WIDTH'(1) << m_axi_arsize);
            default:     next_addr = m_axi_araddr + (AXI_ADDR_WIDTH'(1) << m_axi_arsize);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            s_axi_arready <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
            m_axi_aruser  <= '0;
            beats_left    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        m_axi_arid    <= s_axi_arid;
                        m_axi_araddr  <= s_axi_araddr;
                        m_axi_arsize  <= s_axi_arsize;
                        m_axi_arburst <= s_axi_arburst;
                        m_axi_aruser  <= s_axi_aruser;
                        beats_left    <= s_axi_arlen;
                        s_axi_arready <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        state         <= ISSUE;
                    end else begin
                        s_axi_arready <= arready_idle;
                    end
                end
                ISSUE: begin
                    if (m_axi_arready) begin
                        if (beats_left == 8'd0) begin
                            m_axi_arvalid <= 1'b0;
                            s_axi_arready <= arready_idle;
                            state         <= IDLE;
                        end else begin
                            beats_left    <= beats_left - 8'd1;
                            m_axi_araddr  <= next_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat position within the burst at the FIFO head.
    always_ff @(posedge clk) begin
        if (rst)
            rcnt <= '0;
        else if (r_hs)
            rcnt <= s_axi_rlast ? 8'd0 : rcnt + 8'd1;
    end

    svc_sync_fifo_n #(
        .ADDR_WIDTH (OUTSTANDING_BURSTS_WIDTH),
        .DATA_WIDTH (8)
    ) u_len_fifo (
        .clk     (clk),
        .rst_n   (!rst),
        .wr_en   (ar_hs),
        .wr_data (s_axi_arlen),
        .rd_en   (pop),
        .rd_data (head_len),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axi_arlen  = 8'd0;
    assign s_axi_rvalid = m_axi_rvalid && len_valid;
    assign m_axi_rready = s_axi_rready && len_valid;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_ruser  = m_axi_ruser;
    assign s_axi_rlast  = (rcnt == head_len);
endmodule

// File: tb/tb_svc_axi_rd_burst_split.sv
// Bench for svc_axi_rd_burst_split: directed vector table, multi-cycle corner
// sequences and randomized backpressure against a burst-expansion model.
module tb_svc_axi_rd_burst_split;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_arid = '0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic [2:0]    s_axi_arsize = '0;
    logic [1:0]    s_axi_arburst = '0;
    logic [UW-1:0] s_axi_aruser = '0;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic [UW-1:0] s_axi_ruser;
    logic          s_axi_rlast;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [UW-1:0] m_axi_aruser;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic [IW-1:0] m_axi_rid = '0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic [UW-1:0] m_axi_ruser = '0;

    svc_axi_rd_burst_split dut (
        .clk(clk), .rst(rst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_aruser(s_axi_aruser),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_ruser(s_axi_ruser), .s_axi_rlast(s_axi_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_aruser(m_axi_aruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_ruser(m_axi_ruser)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [UW-1:0] user;
    } ar_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic [UW-1:0] user;
        logic          last;
    } r_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        int            exp_beats;
        logic [AW-1:0] exp_last;
    } vec_t;

    ar_t  exp_ar[$];
    r_t   exp_r[$];
    ar_t  rq[$];
    vec_t vt[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int r_fire_cnt = 0;
    int seen_fire = 0;
    int arready_pct = 100;
    int rready_pct = 100;
    int rvalid_pct = 100;
    int m_beats = 0;
    int rlast_cnt = 0;
    int pop_edge = 0;
    int last_m_edge = 0;
    logic [AW-1:0] last_m_addr = '0;
    logic          ar_pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Downstream memory model: answers each issued single-beat read in order.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        m_axi_arready = int'($urandom_range(99)) < arready_pct;
        s_axi_rready  = int'($urandom_range(99)) < rready_pct;
        if (rst || rq.size() == 0)
            m_axi_rvalid = 1'b0;
        else if (!(m_axi_rvalid && r_fire_cnt == seen_fire))
            m_axi_rvalid = int'($urandom_range(99)) < rvalid_pct;
        seen_fire = r_fire_cnt;
        if (rq.size() > 0) begin
            m_axi_rid   = rq[0].id;
            m_axi_rdata = beat_data(rq[0].addr);
            m_axi_rresp = rq[0].addr[2:1];
            m_axi_ruser = rq[0].addr[0];
        end
    end

    // Observe handshakes that complete at the coming rising edge.
    always @(negedge clk) begin
        ar_t a;
        r_t  r;
        if (rst) begin
            exp_ar.delete();
            exp_r.delete();
            rq.delete();
            ar_pend = 1'b0;
        end else begin
            if (ar_pend)
                chk("m_ar_stable", 32'({m_axi_arvalid, m_axi_araddr}), 32'({1'b1, pend_addr}));
            ar_pend   = m_axi_arvalid && !m_axi_arready;
            pend_addr = m_axi_araddr;

            if (s_axi_arvalid && s_axi_arready) begin
                for (int k = 0; k <= int'(s_axi_arlen); k++) begin
                    a.id    = s_axi_arid;
                    a.size  = s_axi_arsize;
                    a.burst = s_axi_arburst;
                    a.user  = s_axi_aruser;
                    a.addr  = (s_axi_arburst == 2'b00) ? s_axi_araddr
                            : AW'(int'(s_axi_araddr) + k * (1 << int'(s_axi_arsize)));
                    exp_ar.push_back(a);
                    r.id   = s_axi_arid;
                    r.data = beat_data(a.addr);
                    r.resp = a.addr[2:1];
                    r.user = a.addr[0];
                    r.last = (k == int'(s_axi_arlen));
                    exp_r.push_back(r);
                end
            end

            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar.size() == 0) begin
                    chk("m_ar_unexpected", 32'(1), 32'(0));
                end else begin
                    a = exp_ar.pop_front();
                    chk("m_araddr", 32'(m_axi_araddr), 32'(a.addr));
                    chk("m_arid", 32'(m_axi_arid), 32'(a.id));
                    chk("m_arlen", 32'(m_axi_arlen), 32'(0));
                    chk("m_arsize", 32'(m_axi_arsize), 32'(a.size));
                    chk("m_arburst", 32'(m_axi_arburst), 32'(a.burst));
                    chk("m_aruser", 32'(m_axi_aruser), 32'(a.user));
                    rq.push_back(a);
                end
                m_beats++;
                last_m_addr = m_axi_araddr;
                last_m_edge = cyc + 1;
            end

            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    chk("s_r_unexpected", 32'(1), 32'(0));
                end else begin
                    r = exp_r.pop_front();
                    chk("s_rid", 32'(s_axi_rid), 32'(r.id));
                    chk("s_rdata", 32'(s_axi_rdata), 32'(r.data));
                    chk("s_rresp", 32'(s_axi_rresp), 32'(r.resp));
                    chk("s_ruser", 32'(s_axi_ruser), 32'(r.user));
                    chk("s_rlast", 32'(s_axi_rlast), 32'(r.last));
                end
                if (s_axi_rlast) begin
                    rlast_cnt++;
                    pop_edge = cyc + 1;
                end
            end

            if (m_axi_rvalid && m_axi_rready) begin
                if (rq.size() > 0)
                    void'(rq.pop_front());
                r_fire_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [UW-1:0] user);
        int n;
        n = 0;
        s_axi_arvalid = 1'b1;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_aruser  = user;
        while (!s_axi_arready && n < 1000) begin
            step();
            n++;
        end
        chk("ar_accept_timeout", 32'(n >= 1000), 32'(0));
        step();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_ar.size() != 0 || exp_r.size() != 0) && n < 5000) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n >= 5000), 32'(0));
        repeat (2) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int l0;
        int n;
        int hs_edge;

        vt[0] = '{4'd3, 8'h10, 8'd0,   3'd0, 2'b01, 1,   8'h10};
        vt[1] = '{4'd5, 8'h20, 8'd3,   3'd1, 2'b01, 4,   8'h26};
        vt[2] = '{4'd9, 8'h40, 8'd2,   3'd2, 2'b00, 3,   8'h40};
        vt[3] = '{4'd1, 8'hFC, 8'd1,   3'd2, 2'b01, 2,   8'h00};
        vt[4] = '{4'd7, 8'h30, 8'd2,   3'd0, 2'b10, 3,   8'h32};
        vt[5] = '{4'd2, 8'h00, 8'd3,   3'd7, 2'b01, 4,   8'h80};
        vt[6] = '{4'hF, 8'h00, 8'd255, 3'd0, 2'b01, 256, 8'hFF};

        // Reset state and first cycle out of reset.
        step();
        step();
        chk("rst_s_arready", 32'(s_axi_arready), 32'(0));
        chk("rst_m_arvalid", 32'(m_axi_arvalid), 32'(0));
        chk("rst_s_rvalid", 32'(s_axi_rvalid), 32'(0));
        rst = 1'b0;
        step();
        chk("post_rst_s_arready", 32'(s_axi_arready), 32'(1));
        chk("post_rst_m_arvalid", 32'(m_axi_arvalid), 32'(0));

        // Directed bursts, no backpressure: beat count, final address, timing.
        for (int i = 0; i < 7; i++) begin
            b0 = m_beats;
            l0 = rlast_cnt;
            send_burst(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, UW'(i));
            hs_edge = cyc;
            chk("vec_first_arvalid", 32'(m_axi_arvalid), 32'(1));
            wait_idle();
            chk("vec_beats", 32'(m_beats - b0), 32'(vt[i].exp_beats));
            chk("vec_last_addr", 32'(last_m_addr), 32'(vt[i].exp_last));
            chk("vec_last_edge", 32'(last_m_edge), 32'(hs_edge + vt[i].exp_beats));
            chk("vec_rlast_count", 32'(rlast_cnt - l0), 32'(1));
        end

        // Length FIFO full: third burst stalls until the first burst's beat pops.
        rready_pct = 0;
        send_burst(4'd1, 8'h60, 8'd0, 3'd0, 2'b01, 1'b0);
        send_burst(4'd2, 8'h61, 8'd0, 3'd0, 2'b01, 1'b0);
        s_axi_arvalid = 1'b1;
        s_axi_arid    = 4'd3;
        s_axi_araddr  = 8'h62;
        s_axi_arlen   = 8'd0;
        repeat (8) step();
        chk("full_stall_arready", 32'(s_axi_arready), 32'(0));
        rready_pct = 100;
        n = 0;
        while (!s_axi_arready && n < 100) begin
            step();
            n++;
        end
        chk("pop_to_arready_edge", 32'(cyc), 32'(pop_edge));
        step();
        s_axi_arvalid = 1'b0;
        wait_idle();

        // Randomized bursts under backpressure on every handshake.
        arready_pct = 60;
        rready_pct  = 60;
        rvalid_pct  = 70;
        l0 = rlast_cnt;
        for (int i = 0; i < 50; i++) begin
            send_burst(IW'($urandom), AW'($urandom), 8'($urandom_range(0, 20)),
                       3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), UW'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();
        chk("rand_rlast_count", 32'(rlast_cnt - l0), 32'(50));
        arready_pct = 100;
        rready_pct  = 100;
        rvalid_pct  = 100;

        // Reset while beat 2 of a six-beat burst is being presented.
        send_burst(4'd2, 8'h80, 8'd5, 3'd0, 2'b01, 1'b0);
        step();
        step();
        chk("mid_beat2_addr", 32'(m_axi_araddr), 32'(8'h82));
        chk("mid_beat2_valid", 32'(m_axi_arvalid), 32'(1));
        rst = 1'b1;
        step();
        chk("mid_rst_m_arvalid", 32'(m_axi_arvalid), 32'(0));
        chk("mid_rst_s_arready", 32'(s_axi_arready), 32'(0));
        rst = 1'b0;
        step();
        chk("mid_rst_release_arready", 32'(s_axi_arready), 32'(1));
        b0 = m_beats;
        l0 = rlast_cnt;
        send_burst(4'd6, 8'h50, 8'd2, 3'd0, 2'b01, 1'b1);
        wait_idle();
        chk("after_rst_beats", 32'(m_beats - b0), 32'(3));
        chk("after_rst_last_addr", 32'(last_m_addr), 32'(8'h52));
        chk("after_rst_rlast_count", 32'(rlast_cnt - l0), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/svc_axi_rd_burst_split.md
# svc_axi_rd_burst_split

Read-path burst splitter. It accepts AXI read bursts (INCR or FIXED, arlen 0..255) on a subordinate port and reissues each one as arlen+1 single-beat AXI reads on a manager port, all with the same id, user, size and burst. It sits directly upstream of the AXI-to-AXI-Lite read reflector, which only handles single-beat bursts. It regenerates rlast on the returning beats so the upstream manager sees a well-formed burst.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 8, address width
- AXI_DATA_WIDTH, 16, data width
- AXI_ID_WIDTH, 4, id width
- AXI_USER_WIDTH, 1, user width
- OUTSTANDING_BURSTS_WIDTH, 1, log2 of the number of bursts accepted but not fully returned

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_arvalid / s_axi_arready  in / out  1  burst request handshake
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_aruser  in  ID/ADDR/8/3/2/USER  burst request fields
- s_axi_rvalid / s_axi_rready  out / in  1  beat return handshake
- s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_ruser  out  ID/DATA/2/USER  passed through from m_axi_r*
- s_axi_rlast  out  1  regenerated last-beat flag
- m_axi_arvalid / m_axi_arready  out / in  1  single-beat request handshake
- m_axi_arid, m_axi_araddr, m_axi_arsize, m_axi_arburst, m_axi_aruser  out  ID/ADDR/3/2/USER  beat request fields, registered
- m_axi_arlen  out  8  constant 0
- m_axi_rvalid / m_axi_rready  in / out  1  beat return handshake
- m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_ruser  in  ID/DATA/2/USER  beat return fields

## Operation
AR FSM, states IDLE and ISSUE.
- IDLE: s_axi_arready = 1 iff the length FIFO is not full. On AR handshake:
  - latch id/user/size/burst and addr into m_axi_ar* registers;
  - load beats_left = arlen;
  - push arlen into the length FIFO;
  - go to ISSUE.
- ISSUE: m_axi_arvalid = 1. On m_axi_ar handshake:
  - if beats_left == 0, go to IDLE;
  - otherwise decrement beats_left and advance the address. INCR: addr += (1 << arsize), modulo 2^AXI_ADDR_WIDTH. FIXED: addr unchanged.
- No 4 KB crossing logic; legal AXI bursts never cross a 4 KB boundary. arburst = WRAP is unsupported and is processed as INCR.

R path:
- Combinational pass-through of data, id, user and resp.
- s_axi_rvalid = m_axi_rvalid && len_valid.
- m_axi_rready = s_axi_rready && len_valid.
- Beat counter rcnt (8 bit). s_axi_rlast = (rcnt == FIFO head length).
- On an R handshake: if rlast, set rcnt to 0 and pop the FIFO; otherwise increment rcnt.
- rresp is passed per beat; an error on one beat does not cancel the remaining beats.

## Timing
- Reset values: s_axi_arready 0, m_axi_arvalid 0, FSM in IDLE, rcnt 0, FIFO empty, m_axi_ar* field registers 0.
- Cycle after reset deasserts: s_axi_arready = 1.
- s_axi_arready is a registered signal, never combinational from s_axi_arvalid.
- AR handshake at cycle N: m_axi_arvalid rises at N+1 with beat 0.
- With m_axi_arready held high, one beat issues per cycle, so beat k issues at N+1+k.
- s_axi_arready returns in the cycle after the last beat handshake. This gives one bubble cycle between back-to-back bursts.
- m_axi_arvalid and its fields stay stable until m_axi_arready is seen.
- R latency is zero cycles (combinational).
- Length FIFO full (2^OUTSTANDING_BURSTS_WIDTH bursts outstanding): s_axi_arready stays 0 until a last beat pops the FIFO.
- Pop and push in the same cycle are allowed; occupancy is unchanged.
- Pop on a full FIFO makes s_axi_arready 1 on the next cycle.
- m_axi_rvalid while the FIFO is empty is a protocol error. The beat is stalled (not dropped) because m_axi_rready = 0.
- Reset mid-burst: all state clears in one cycle. Any in-flight downstream beats are the system's responsibility; the whole domain resets together.

## Structure
- No shared package is needed; FSM state is a local enum, and the burst encodings (FIXED = 2'b00, INCR = 2'b01) are localparams.
- One sub-module: svc_sync_fifo_n (ADDR_WIDTH = OUTSTANDING_BURSTS_WIDTH, DATA_WIDTH = 8) as the length FIFO. Because it resets active-low, drive its rst_n from !rst.

## Test plan
- arlen = 0, araddr 0x10, id 3: exactly one m_axi AR, to 0x10 with arlen 0 and id 3; the single R beat has rlast = 1 and rid 3.
- INCR, arlen = 3, arsize = 1, araddr 0x20: m_axi_araddr sequence 0x20, 0x22, 0x24, 0x26; rlast = 1 only on the 4th beat.
- FIXED, arlen = 2, araddr 0x40: three m_axi ARs, all to 0x40; rlast on the 3rd beat.
- OUTSTANDING_BURSTS_WIDTH = 1, three arlen = 0 bursts with s_axi_rready held 0: third AR stalls with s_axi_arready = 0 until the first R beat completes.
- Random m_axi_arready and s_axi_rready backpressure over 50 bursts with random lengths: every beat is delivered in order, with the correct rid and exactly one rlast per burst.
- Assert rst during beat 2 of an arlen = 5 burst: the next cycle shows m_axi_arvalid 0 and s_axi_arready 0; the cycle after shows s_axi_arready 1; a new burst then runs cleanly.
